fb_fifo_reader: RTL and testbench
=================================

# fb_fifo_reader

FPGA-side consumer of the framebuffer command FIFO. Acts as an Avalon-MM read master on the FIFO's read slave, pops 64-bit words whenever the FIFO is non-empty and local buffering allows, and deframes them into a tagged command-beat stream for the rasterizer/framebuffer engine. Sits between the FIFO read port and the downstream valid/ready command consumer, on the FIFO's clock.

## Interface
- DATA_WIDTH, 64: FIFO word width; fixed, matches the FIFO.
- LEN_WIDTH, 16: payload-length field width in the header word.
- OUT_DEPTH, 4: output skid-buffer entries; power of two, ≥2.

- clock  in  1  single clock, shared with the FIFO.
- reset_n  in  1  synchronous, active-low reset.
- avm_read  out  1  read request to the FIFO read slave.
- avm_waitrequest  in  1  high = FIFO empty; read not accepted.
- avm_readdata  in  64  FIFO output; valid the cycle after an accepted read (non-showahead).
- cmd_valid  out  1  beat available.
- cmd_ready  in  1  downstream accepts beat.
- cmd_data  out  64  beat word (header or payload).
- cmd_opcode  out  8  opcode of the packet this beat belongs to.
- cmd_sop  out  1  beat is a header.
- cmd_eop  out  1  last beat of the packet.
- pkt_count  out  32  packets fully accepted downstream; wraps.
- idle  out  1  no beats buffered, none in flight, FSM in HDR.

## Operation
- Read acceptance: avm_read & ~avm_waitrequest. The accepted word is captured from avm_readdata on the following cycle.
- avm_read is driven from registered state only, never combinationally from avm_waitrequest. It is asserted iff occupancy + inflight < OUT_DEPTH, where occupancy is the registered buffer count and inflight is 1 if a read was accepted last cycle. A same-cycle downstream pop is not credited.
- Deframer FSM on each captured word:
  - HDR: word is a header. opcode = word[63:56], len = word[15:0]. Emit the beat with sop=1, eop=(len==0). If len!=0, set remaining=len and go to PAY.
  - PAY: emit the beat with sop=0 and the latched opcode, then decrement remaining. eop=(remaining==1). At eop, return to HDR.
  - len 0 gives a single-beat packet. len 65535 gives a 65536-beat packet with no overflow; remaining is LEN_WIDTH bits.
- Each emitted beat {data, opcode, sop, eop} is written into the output buffer. The buffer head drives the cmd_* ports. A beat is accepted when cmd_valid & cmd_ready.
- pkt_count increments by 1 on each accepted beat with eop=1, wrapping from 0xFFFF_FFFF to 0.
- cmd_data and cmd_opcode are held stable while cmd_valid & ~cmd_ready.

## Timing
- Reset values: avm_read=0, cmd_valid=0, cmd_sop=0, cmd_eop=0, cmd_data=0, cmd_opcode=0, pkt_count=0, idle=1. FSM=HDR, remaining=0, inflight=0, buffer empty.
- Reset mid-packet discards buffered beats, the in-flight word, and the partial-packet state. The FIFO shares reset_n, so no stale word returns after reset.
- Latency: read accepted in cycle N → word captured at the end of N+1 → cmd_valid in N+2.
- Throughput: 1 beat/cycle sustained while the FIFO is non-empty and cmd_ready is held high.
- Buffer full with one word in flight: the in-flight word always has a free slot, guaranteed by the credit rule. Overflow is impossible; the bench asserts this.
- Simultaneous buffer write and read in one cycle: occupancy unchanged, order preserved.
- FIFO going empty mid-packet: the FSM holds in PAY with remaining unchanged until more words arrive.

## Structure
- Package fb_fifo_pkg holds:
  - OPCODE_MSB/LSB (63/56) and LEN_MSB/LSB (15/0)
  - DATA_WIDTH and LEN_WIDTH constants
  - the deframer state enum {HDR, PAY}
  - the beat struct {data, opcode, sop, eop}
- Sub-module fb_fifo_reader_buf: a synchronous FIFO of beat structs, OUT_DEPTH entries, with count output. Registered head drives the cmd_* ports.
- Top level contains the credit logic, capture register, FSM, and pkt_count.

## Test plan
- Header 0x0100_0000_0000_0000 (opcode 1, len 0), cmd_ready=1 → one beat, sop=1, eop=1, opcode=0x01, pkt_count 0→1, cmd_valid 2 cycles after read acceptance.
- Header opcode 0x22 len 3, then 3 payloads, cmd_ready=1, FIFO pre-filled → 4 beats on consecutive cycles; sop only on the first, eop only on the 4th, opcode 0x22 on all.
- Same packet with cmd_ready=0 for 20 cycles → avm_read deasserts once occupancy+inflight=4; no word lost; release cmd_ready → all 4 beats in order.
- FIFO empty between payload words 1 and 2 (avm_waitrequest=1 for 10 cycles) → no spurious beats; eop still on word 3; idle=0 throughout.
- reset_n=0 for 1 cycle after payload 1 of a len-3 packet → all outputs at reset values next cycle; a new header is then decoded as sop=1.
- 1000 random packets, len 0–40, random cmd_ready → scoreboard matches every beat; pkt_count=1000; no buffer overflow assertion fires.

Source files
------------

// File: rtl/fb_fifo_pkg.sv
// fb_fifo_pkg: shared field positions, widths, deframer states and beat type
package fb_fifo_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 16;
  localparam int OPCODE_MSB = 63;
  localparam int OPCODE_LSB = 56;
  localparam int LEN_MSB    = 15;
  localparam int LEN_LSB    = 0;
  typedef enum logic {HDR, PAY} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [7:0]            opcode;
    logic                  sop;
    logic                  eop;
  } beat_t;
endpackage

// File: rtl/fb_fifo_reader_buf.sv
// fb_fifo_reader_buf: small synchronous FIFO of beats with occupancy count
module fb_fifo_reader_buf
  import fb_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    wr,
  input  beat_t   wdata,
  input  logic    rd,
  output beat_t   head,
  output logic [AW:0] count
);
  beat_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, push, pop;
  assign full = count == (AW+1)'(DEPTH);
  assign pop  = rd && count != '0;
  assign push = wr && (!full || pop);
  assign head = mem[rp];
  always_ff @(posedge clock)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fb_fifo_reader.sv
// fb_fifo_reader: Avalon-MM FIFO read master that deframes words into a tagged command-beat stream
module fb_fifo_reader
  import fb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic [7:0]            cmd_opcode,
  output logic                  cmd_sop,
  output logic                  cmd_eop,
  output logic [31:0]           pkt_count,
  output logic                  idle
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  state_t state, state_d;
  logic [LEN_WIDTH-1:0] rem, rem_d, len;
  logic [7:0] op, op_d;
  logic inflight, run;
  logic [CW-1:0] count;
  beat_t beat, head;
  // the word in flight always owns a slot, so a same-cycle pop is deliberately not credited
  assign avm_read   = run && (32'(count) + 32'(inflight) < 32'(OUT_DEPTH));
  assign len        = LEN_WIDTH'(avm_readdata[LEN_MSB:LEN_LSB]);
  assign cmd_valid  = count != '0;
  assign cmd_data   = cmd_valid ? head.data : '0;
  assign cmd_opcode = cmd_valid ? head.opcode : '0;
  assign cmd_sop    = cmd_valid && head.sop;
  assign cmd_eop    = cmd_valid && head.eop;
  assign idle       = !cmd_valid && !inflight && state == HDR;
  always_comb begin
    state_d     = state;
    rem_d       = rem;
    op_d        = op;
    beat.data   = avm_readdata;
    beat.opcode = state == HDR ? avm_readdata[OPCODE_MSB:OPCODE_LSB] : op;
    beat.sop    = state == HDR;
    beat.eop    = state == HDR ? len == '0 : rem == LEN_WIDTH'(1);
    if (inflight && state == HDR) begin
      op_d    = beat.opcode;
      rem_d   = len;
      state_d = len == '0 ? HDR : PAY;
    end else if (inflight) begin
      rem_d   = rem - LEN_WIDTH'(1);
      state_d = beat.eop ? HDR : PAY;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= HDR;
      rem       <= '0;
      op        <= '0;
      inflight  <= 1'b0;
      run       <= 1'b0;
      pkt_count <= '0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      op        <= op_d;
      inflight  <= avm_read && !avm_waitrequest;
      run       <= 1'b1;
      pkt_count <= pkt_count + 32'(cmd_valid && cmd_ready && cmd_eop);
    end
  end
  fb_fifo_reader_buf #(.DEPTH(OUT_DEPTH)) u_buf (
    .clock  (clock),
    .reset_n(reset_n),
    .wr     (inflight),
    .wdata  (beat),
    .rd     (cmd_ready),
    .head   (head),
    .count  (count)
  );
endmodule

// File: tb/tb_fb_fifo_reader.sv
// tb_fb_fifo_reader: FIFO model plus scoreboard for the command-beat deframer
module tb_fb_fifo_reader;
  import fb_fifo_pkg::*;
  logic clock = 0, reset_n = 0, avm_read, avm_waitrequest = 1;
  logic cmd_valid, cmd_ready = 1, cmd_sop, cmd_eop, idle;
  logic [63:0] avm_readdata = '0, cmd_data, hold_data = '0;
  logic [7:0] cmd_opcode, hold_op = '0, cur_op = '0;
  logic [31:0] pkt_count;
  logic acc = 0, stall = 0, prev_valid = 0, hold = 0;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, rise_cyc = 0, last_pop = -10, run_len = 0, cur_left = 0;
  logic [63:0] fifo_q[$];
  beat_t exp_q[$];
  beat_t e;

  fb_fifo_reader dut (
    .clock(clock), .reset_n(reset_n), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_opcode(cmd_opcode), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop), .pkt_count(pkt_count), .idle(idle)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // non-showahead FIFO: a read accepted in one cycle presents its word in the next
  always @(negedge clock) begin
    acc = avm_read && !avm_waitrequest && reset_n;
    if (acc) acc_cyc = cyc;
  end
  always @(posedge clock) begin
    #1;
    if (acc) avm_readdata = fifo_q.pop_front();
    avm_waitrequest = stall || fifo_q.size() == 0;
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("overflow", 64'(dut.u_buf.wr && dut.u_buf.full && !dut.u_buf.pop), 64'(0));
      if (hold) begin
        check("hold data", cmd_data, hold_data);
        check("hold opcode", 64'(cmd_opcode), 64'(hold_op));
      end
      if (cmd_valid && !prev_valid) rise_cyc = cyc;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious beat: got data 0x%0h, expected no beat", cmd_data);
        end else begin
          e = exp_q.pop_front();
          check("beat data", cmd_data, e.data);
          check("beat opcode", 64'(cmd_opcode), 64'(e.opcode));
          check("beat sop/eop", 64'({cmd_sop, cmd_eop}), 64'({e.sop, e.eop}));
        end
        run_len = (last_pop == cyc - 1) ? run_len + 1 : 1;
        last_pop = cyc;
      end
    end
    hold = reset_n && cmd_valid && !cmd_ready;
    hold_data = cmd_data;
    hold_op = cmd_opcode;
    prev_valid = reset_n && cmd_valid;
  end

  task automatic push_hdr(input logic [7:0] op, input logic [15:0] len, input logic [39:0] mid);
    logic [63:0] w;
    w = {op, mid, len};
    fifo_q.push_back(w);
    exp_q.push_back('{data: w, opcode: op, sop: 1'b1, eop: len == 16'd0});
    cur_op = op;
    cur_left = int'(len);
  endtask

  task automatic push_pay();
    logic [63:0] w;
    w = {$urandom, $urandom};
    fifo_q.push_back(w);
    exp_q.push_back('{data: w, opcode: cur_op, sop: 1'b0, eop: cur_left == 1});
    cur_left--;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [15:0] len, input logic [39:0] mid);
    push_hdr(op, len, mid);
    repeat (int'(len)) push_pay();
  endtask

  task automatic drain(input string name, input int budget, input bit rnd);
    checks++;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && idle) return;
      if (rnd) begin
        cmd_ready = $urandom_range(3) != 0;
        stall = $urandom_range(7) == 0;
      end
      tick();
    end
    errors++;
    $display("FAIL %s: drain timeout, %0d beats outstanding, expected 0", name, exp_q.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " avm_read"}, 64'(avm_read), 64'(0));
    check({tag, " cmd_valid"}, 64'(cmd_valid), 64'(0));
    check({tag, " cmd_sop"}, 64'(cmd_sop), 64'(0));
    check({tag, " cmd_eop"}, 64'(cmd_eop), 64'(0));
    check({tag, " cmd_data"}, cmd_data, 64'(0));
    check({tag, " cmd_opcode"}, 64'(cmd_opcode), 64'(0));
    check({tag, " pkt_count"}, 64'(pkt_count), 64'(0));
    check({tag, " idle"}, 64'(idle), 64'(1));
  endtask

  initial begin
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1;
    tick();
    push_hdr(8'h01, 16'd0, 40'h0);
    drain("single", 50, 0);
    check("single latency", 64'(rise_cyc - acc_cyc), 64'd2);
    check("single pkt_count", 64'(pkt_count), 64'd1);
    stall = 1;
    send_pkt(8'h22, 16'd3, 40'h12_3456_789A);
    tick(3);
    stall = 0;
    drain("burst", 50, 0);
    check("burst consecutive beats", 64'(run_len), 64'd4);
    check("burst pkt_count", 64'(pkt_count), 64'd2);
    cmd_ready = 0;
    send_pkt(8'h33, 16'd3, 40'hAB);
    push_hdr(8'h44, 16'd0, 40'hCD);
    tick(20);
    check("backpressure avm_read", 64'(avm_read), 64'(0));
    check("backpressure words left", 64'(fifo_q.size()), 64'd1);
    check("backpressure cmd_valid", 64'(cmd_valid), 64'(1));
    cmd_ready = 1;
    drain("backpressure", 60, 0);
    check("backpressure pkt_count", 64'(pkt_count), 64'd4);
    push_hdr(8'h55, 16'd3, 40'h77);
    push_pay();
    tick(4);
    repeat (10) begin
      check("gap idle", 64'(idle), 64'(0));
      check("gap waitrequest", 64'(avm_waitrequest), 64'(1));
      tick();
    end
    push_pay();
    push_pay();
    drain("gap", 50, 0);
    check("gap pkt_count", 64'(pkt_count), 64'd5);
    cmd_ready = 0;
    push_hdr(8'h66, 16'd3, 40'h99);
    push_pay();
    tick(6);
    reset_n = 0;
    exp_q.delete();
    cur_left = 0;
    tick();
    check_reset_outputs("mid-packet reset");
    reset_n = 1;
    cmd_ready = 1;
    push_hdr(8'h77, 16'd0, 40'h5);
    drain("after reset", 50, 0);
    check("after reset pkt_count", 64'(pkt_count), 64'd1);
    reset_n = 0;
    tick(2);
    reset_n = 1;
    for (int p = 0; p < 1000; p++)
      send_pkt(8'($urandom), 16'($urandom_range(40)), {$urandom, 8'($urandom)});
    drain("random", 60000, 1);
    cmd_ready = 1;
    stall = 0;
    tick(2);
    check("random pkt_count", 64'(pkt_count), 64'd1000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
